// File: rtl/fa.sv
// Full adder with registered outputs and a bit-serial adder that accumulates a 32-bit word.
// Optional registered-output self-check enabled by defining FA_CHECK_EN.
module fa (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        Cin,
    output logic        S,
    output logic        Cout,
    input  logic        ser_en,
    input  logic        ser_start,
    output logic        s_q,
    output logic        cout_q,
    output logic        ser_s,
    output logic        carry_q,
    output logic [7:0]  bit_cnt,
    output logic [31:0] sum_word,
    output logic        word_done,
    output logic        err
);

    logic cin_eff;
    logic new_bit;
    logic new_carry;

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

    // A new word ignores the carry left over from the previous word.
    always_comb begin
        cin_eff   = ser_start ? Cin : carry_q;
        new_bit   = A ^ B ^ cin_eff;
        new_carry = (A & B) | (A & cin_eff) | (B & cin_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= 1'b0;
            cout_q   <= 1'b0;
            ser_s    <= 1'b0;
            carry_q  <= 1'b0;
            bit_cnt  <= 8'd0;
            sum_word <= 32'd0;
        end else begin
            s_q    <= S;
            cout_q <= Cout;
            if (ser_en) begin
                ser_s   <= new_bit;
                carry_q <= new_carry;
                if (ser_start) begin
                    sum_word <= {new_bit, 31'b0};
                    bit_cnt  <= 8'd1;
                end else begin
                    sum_word <= {new_bit, sum_word[31:1]};
                    if (bit_cnt != 8'hff)
                        bit_cnt <= bit_cnt + 8'd1;
                end
            end
        end
    end

    assign word_done = (bit_cnt == 8'd32);

`ifdef FA_CHECK_EN
    logic [2:0] abc_q;
    logic [1:0] abc_sum;
    logic       err_q;

    // Registered outputs must equal the arithmetic sum of the inputs captured on the same edge.
    assign abc_sum = {1'b0, abc_q[2]} + {1'b0, abc_q[1]} + {1'b0, abc_q[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            abc_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            abc_q <= {A, B, Cin};
            if ({cout_q, s_q} != abc_sum)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: directed cases plus randomized traffic against
// an arithmetic reference model of the adder and serial word.
module tb_fa;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b1;
    logic        a_in = 1'b0, b_in = 1'b0, cin_in = 1'b0;
    logic        ser_en = 1'b0, ser_start = 1'b0;
    logic        S, Cout, s_q, cout_q, ser_s, carry_q, word_done, err;
    logic [7:0]  bit_cnt;
    logic [31:0] sum_word;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_sq = 0, m_cq = 0, m_ser = 0, m_carry = 0, m_cnt = 0;
    int m_bits[$];

    fa dut (
        .clk(clk), .rst(rst), .A(a_in), .B(b_in), .Cin(cin_in),
        .S(S), .Cout(Cout), .ser_en(ser_en), .ser_start(ser_start),
        .s_q(s_q), .cout_q(cout_q), .ser_s(ser_s), .carry_q(carry_q),
        .bit_cnt(bit_cnt), .sum_word(sum_word), .word_done(word_done), .err(err)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = 32'd0;
        int n = m_bits.size();
        for (int i = 0; i < n; i++)
            w[32 - n + i] = m_bits[i][0];
        return w;
    endfunction

    task automatic model_edge(input int a, input int b, input int c, input int en, input int st, input int r);
        int t;
        if (r != 0) begin
            m_sq = 0; m_cq = 0; m_ser = 0; m_carry = 0; m_cnt = 0;
            m_bits.delete();
        end else begin
            m_sq = (a + b + c) % 2;
            m_cq = (a + b + c) / 2;
            if (en != 0) begin
                t = a + b + ((st != 0) ? c : m_carry);
                m_ser   = t % 2;
                m_carry = t / 2;
                if (st != 0) begin
                    m_bits.delete();
                    m_cnt = 1;
                end else begin
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
                m_bits.push_back(m_ser);
                if (m_bits.size() > 32) void'(m_bits.pop_front());
            end
        end
    endtask

    task automatic check_all();
        int sum = int'(a_in) + int'(b_in) + int'(cin_in);
        check("S",         32'(S),         32'(sum % 2));
        check("Cout",      32'(Cout),      32'(sum / 2));
        check("s_q",       32'(s_q),       32'(m_sq));
        check("cout_q",    32'(cout_q),    32'(m_cq));
        check("ser_s",     32'(ser_s),     32'(m_ser));
        check("carry_q",   32'(carry_q),   32'(m_carry));
        check("bit_cnt",   32'(bit_cnt),   32'(m_cnt));
        check("sum_word",  sum_word,       model_word());
        check("word_done", 32'(word_done), 32'(m_cnt == 32));
        check("err",       32'(err),       32'd0);
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic tick(input logic a, input logic b, input logic c, input logic en, input logic st, input logic r);
        a_in = a; b_in = b; cin_in = c; ser_en = en; ser_start = st; rst = r;
        @(posedge clk);
        model_edge(int'(a), int'(b), int'(c), int'(en), int'(st), int'(r));
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] opa, opb;

        // Combinational adder with no clock running and reset asserted.
        for (int i = 0; i < 8; i++) begin
            a_in = i[2]; b_in = i[1]; cin_in = i[0];
            #1;
            check("comb_S",    32'(S),    32'((i[2] + i[1] + i[0]) % 2));
            check("comb_Cout", 32'(Cout), 32'((i[2] + i[1] + i[0]) / 2));
        end

        clk_run = 1'b1;
        @(negedge clk);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Registered outputs hold until the edge.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        a_in = 1'b1; b_in = 1'b1; cin_in = 1'b0;
        #1;
        check("s_q_hold",    32'(s_q),    32'd1);
        check("cout_q_hold", 32'(cout_q), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s_q_11",    32'(s_q),    32'd0);
        check("cout_q_11", 32'(cout_q), 32'd1);

        // 3 + 5 over a full word.
        opa = 32'h3; opb = 32'h5;
        for (int i = 0; i < 32; i++)
            tick(opa[i], opb[i], 1'b0, 1'b1, (i == 0), 1'b0);
        check("word_sum",  sum_word,       32'h8);
        check("word_cy",   32'(carry_q),   32'd0);
        check("word_cnt",  32'(bit_cnt),   32'd32);
        check("word_done", 32'(word_done), 32'd1);

        // ser_en low holds everything, ser_start ignored.
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("hold_cnt", 32'(bit_cnt), 32'd32);

        // Reset mid-word with a pending carry.
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_cy",  32'(carry_q), 32'd0);
        check("rst_cnt", 32'(bit_cnt), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_bit", 32'(ser_s),   32'd1);
        check("post_rst_cy",  32'(carry_q), 32'd0);

        // Saturation of the bit counter.
        for (int i = 0; i < 300; i++)
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        check("sat_cnt",  32'(bit_cnt),   32'd255);
        check("sat_done", 32'(word_done), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("restart_cnt", 32'(bit_cnt), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            tick(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0),
                 ($urandom_range(49, 0) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
